// File: rtl/ir_nec_rx.sv
// NEC IR remote receiver: synchronises IRDA_RXD, times mark/space widths on a 1 us
// timebase and decodes data, stop and repeat frames with key-held tracking.
module ir_nec_rx #(
    parameter int CLK_HZ      = 50000000,
    parameter int FRAME_BITS  = 32,
    parameter int TOL_PCT     = 25,
    parameter int CHECK_INV   = 1,
    parameter int REPEAT_EN   = 1,
    parameter int HOLD_MS     = 120,
    parameter int SYNC_STAGES = 2,
    // Divides every nominal duration and the ms unit; 1 gives true NEC timing.
    parameter int TIME_DIV    = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  IRDA_RXD,
    output logic [FRAME_BITS-1:0] data,
    output logic                  data_valid,
    output logic                  repeat_pulse,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic                  busy,
    output logic                  held
);

    localparam int US_DIV = CLK_HZ / 1000000;
    localparam int PRE_W  = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int IDX_W  = $clog2(FRAME_BITS);

    localparam int N_LEAD = 9000 / TIME_DIV;
    localparam int N_DSP  = 4500 / TIME_DIV;
    localparam int N_RSP  = 2250 / TIME_DIV;
    localparam int N_MARK = 560 / TIME_DIV;
    localparam int N_ZERO = 560 / TIME_DIV;
    localparam int N_ONE  = 1690 / TIME_DIV;

    localparam logic [15:0] LEAD_LO = 16'(N_LEAD * (100 - TOL_PCT) / 100);
    localparam logic [15:0] LEAD_HI = 16'(N_LEAD * (100 + TOL_PCT) / 100);
    localparam logic [15:0] DSP_LO  = 16'(N_DSP * (100 - TOL_PCT) / 100);
    localparam logic [15:0] DSP_HI  = 16'(N_DSP * (100 + TOL_PCT) / 100);
    localparam logic [15:0] RSP_LO  = 16'(N_RSP * (100 - TOL_PCT) / 100);
    localparam logic [15:0] RSP_HI  = 16'(N_RSP * (100 + TOL_PCT) / 100);
    localparam logic [15:0] MARK_LO = 16'(N_MARK * (100 - TOL_PCT) / 100);
    localparam logic [15:0] MARK_HI = 16'(N_MARK * (100 + TOL_PCT) / 100);
    localparam logic [15:0] ZERO_LO = 16'(N_ZERO * (100 - TOL_PCT) / 100);
    localparam logic [15:0] ZERO_HI = 16'(N_ZERO * (100 + TOL_PCT) / 100);
    localparam logic [15:0] ONE_LO  = 16'(N_ONE * (100 - TOL_PCT) / 100);
    localparam logic [15:0] ONE_HI  = 16'(N_ONE * (100 + TOL_PCT) / 100);
    localparam logic [15:0] LSP_MAX = (REPEAT_EN != 0 && RSP_HI > DSP_HI) ? RSP_HI : DSP_HI;

    localparam logic [15:0] MS_LAST   = 16'(1000 / TIME_DIV - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MS - 1);

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REP_MARK
    } state_t;

    state_t                  state_reg, state_next;
    logic [SYNC_STAGES-1:0]  sync_reg;
    logic                    line_reg;
    logic [PRE_W-1:0]        pre_reg;
    logic [15:0]             us_reg;
    logic [15:0]             ms_reg;
    logic [15:0]             hold_reg;
    logic                    held_reg;
    logic [FRAME_BITS-1:0]   shift_reg, shift_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [FRAME_BITS-1:0]   data_reg, data_next;
    logic                    dv_reg, dv_next;
    logic                    rp_reg, rp_next;
    logic                    err_reg, err_next;
    logic [1:0]              code_reg, code_next;
    logic                    hold_restart;
    logic                    timing_err;
    logic [15:0]             max_hi;

    logic rise, fall, edge_det, us_tick, ms_tick, inv_ok;
    logic win_lead, win_dsp, win_rsp, win_mark, win_zero, win_one;

    function automatic logic in_win(input logic [15:0] w, input logic [15:0] lo,
                                    input logic [15:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_reg <= '1;
            line_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], IRDA_RXD};
            line_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rise     = sync_reg[SYNC_STAGES-1] & ~line_reg;
    assign fall     = ~sync_reg[SYNC_STAGES-1] & line_reg;
    assign edge_det = rise | fall;

    assign us_tick = (pre_reg == PRE_W'(US_DIV - 1));
    assign ms_tick = us_tick && (ms_reg == MS_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pre_reg <= '0;
            us_reg  <= '0;
        end else begin
            pre_reg <= us_tick ? '0 : pre_reg + 1'b1;
            if (edge_det)
                us_reg <= '0;
            else if (us_tick && us_reg != 16'hFFFF)
                us_reg <= us_reg + 16'd1;
        end
    end

    assign win_lead = in_win(us_reg, LEAD_LO, LEAD_HI);
    assign win_dsp  = in_win(us_reg, DSP_LO, DSP_HI);
    assign win_rsp  = in_win(us_reg, RSP_LO, RSP_HI);
    assign win_mark = in_win(us_reg, MARK_LO, MARK_HI);
    assign win_zero = in_win(us_reg, ZERO_LO, ZERO_HI);
    assign win_one  = in_win(us_reg, ONE_LO, ONE_HI);

    generate
        if (FRAME_BITS == 32 && CHECK_INV != 0) begin : g_inv
            assign inv_ok = (shift_reg[31:24] == ~shift_reg[23:16]);
        end else begin : g_no_inv
            assign inv_ok = 1'b1;
        end
    endgenerate

    always_comb begin
        max_hi = 16'hFFFF;
        case (state_reg)
            LEAD_MARK:  max_hi = LEAD_HI;
            LEAD_SPACE: max_hi = LSP_MAX;
            BIT_SPACE:  max_hi = ONE_HI;
            BIT_MARK, STOP_MARK, REP_MARK: max_hi = MARK_HI;
            default:    max_hi = 16'hFFFF;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        idx_next     = idx_reg;
        data_next    = data_reg;
        dv_next      = 1'b0;
        rp_next      = 1'b0;
        err_next     = 1'b0;
        code_next    = code_reg;
        hold_restart = 1'b0;
        timing_err   = 1'b0;
        case (state_reg)
            IDLE: if (fall) state_next = LEAD_MARK;
            LEAD_MARK: if (edge_det) begin
                if (rise && win_lead) state_next = LEAD_SPACE;
                else timing_err = 1'b1;
            end
            LEAD_SPACE: if (edge_det) begin
                if (fall && win_dsp) begin
                    state_next = BIT_MARK;
                    idx_next   = '0;
                end else if (fall && REPEAT_EN != 0 && win_rsp) begin
                    state_next = REP_MARK;
                end else begin
                    timing_err = 1'b1;
                end
            end
            BIT_MARK: if (edge_det) begin
                if (rise && win_mark) state_next = BIT_SPACE;
                else timing_err = 1'b1;
            end
            BIT_SPACE: if (edge_det) begin
                if (fall && (win_zero || win_one)) begin
                    // Right shift: the first bit received ends up in bit 0.
                    shift_next = {~win_zero, shift_reg[FRAME_BITS-1:1]};
                    if (idx_reg == IDX_W'(FRAME_BITS - 1)) begin
                        state_next = STOP_MARK;
                    end else begin
                        state_next = BIT_MARK;
                        idx_next   = idx_reg + 1'b1;
                    end
                end else begin
                    timing_err = 1'b1;
                end
            end
            STOP_MARK: if (edge_det) begin
                if (rise && win_mark) begin
                    state_next = IDLE;
                    if (inv_ok) begin
                        data_next    = shift_reg;
                        dv_next      = 1'b1;
                        hold_restart = 1'b1;
                    end else begin
                        err_next  = 1'b1;
                        code_next = 2'd2;
                    end
                end else begin
                    timing_err = 1'b1;
                end
            end
            REP_MARK: if (edge_det) begin
                if (rise && win_mark) begin
                    state_next = IDLE;
                    if (held_reg) begin
                        rp_next      = 1'b1;
                        hold_restart = 1'b1;
                    end else begin
                        err_next  = 1'b1;
                        code_next = 2'd3;
                    end
                end else begin
                    timing_err = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_reg != IDLE && !edge_det && us_reg > max_hi)
            timing_err = 1'b1;
        if (timing_err) begin
            state_next = IDLE;
            err_next   = 1'b1;
            code_next  = 2'd1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            idx_reg   <= '0;
            data_reg  <= '0;
            dv_reg    <= 1'b0;
            rp_reg    <= 1'b0;
            err_reg   <= 1'b0;
            code_reg  <= 2'd0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
            dv_reg    <= dv_next;
            rp_reg    <= rp_next;
            err_reg   <= err_next;
            code_reg  <= code_next;
        end
    end

    // A restart in the expiry cycle takes priority, so held never drops then.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            held_reg <= 1'b0;
            hold_reg <= '0;
            ms_reg   <= '0;
        end else if (hold_restart) begin
            held_reg <= 1'b1;
            hold_reg <= '0;
            ms_reg   <= '0;
        end else if (held_reg) begin
            if (us_tick)
                ms_reg <= ms_tick ? 16'd0 : ms_reg + 16'd1;
            if (ms_tick) begin
                if (hold_reg == HOLD_LAST) begin
                    held_reg <= 1'b0;
                    hold_reg <= '0;
                end else begin
                    hold_reg <= hold_reg + 16'd1;
                end
            end
        end
    end

    assign data         = data_reg;
    assign data_valid   = dv_reg;
    assign repeat_pulse = rp_reg;
    assign err          = err_reg;
    assign err_code     = code_reg;
    assign busy         = (state_reg != IDLE);
    assign held         = held_reg;

endmodule

// File: tb/tb_ir_nec_rx.sv
// Directed bench for ir_nec_rx: a 32-bit instance and a 16-bit instance without
// complement check, both at 1 MHz with every duration divided by 20.
`timescale 1ns/1ps
module tb_ir_nec_rx;

    // Nominal durations in clock cycles (1 cycle = 1 us tick, divided by 20).
    localparam int T_LEAD = 450;
    localparam int T_DSP  = 225;
    localparam int T_RSP  = 112;
    localparam int T_MARK = 28;
    localparam int T_ZERO = 28;
    localparam int T_ONE  = 84;
    localparam int T_BAD  = 50;
    localparam int T_MS   = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ir_a, ir_b;
    logic [31:0] data_a;
    logic        dv_a, rp_a, err_a, busy_a, held_a;
    logic [1:0]  code_a;
    logic [15:0] data_b;
    logic        dv_b, rp_b, err_b, busy_b, held_b;
    logic [1:0]  code_b;

    ir_nec_rx #(
        .CLK_HZ(1000000), .FRAME_BITS(32), .TOL_PCT(25), .CHECK_INV(1),
        .REPEAT_EN(1), .HOLD_MS(120), .SYNC_STAGES(2), .TIME_DIV(20)
    ) dut_a (
        .CLOCK_50(clk), .reset(rst), .IRDA_RXD(ir_a), .data(data_a),
        .data_valid(dv_a), .repeat_pulse(rp_a), .err(err_a), .err_code(code_a),
        .busy(busy_a), .held(held_a)
    );

    ir_nec_rx #(
        .CLK_HZ(1000000), .FRAME_BITS(16), .TOL_PCT(25), .CHECK_INV(0),
        .REPEAT_EN(1), .HOLD_MS(120), .SYNC_STAGES(2), .TIME_DIV(20)
    ) dut_b (
        .CLOCK_50(clk), .reset(rst), .IRDA_RXD(ir_b), .data(data_b),
        .data_valid(dv_b), .repeat_pulse(rp_b), .err(err_b), .err_code(code_b),
        .busy(busy_b), .held(held_b)
    );

    int tests = 0;
    int fails = 0;
    int n_dv_a = 0, n_rp_a = 0, n_err_a = 0, n_dv_b = 0, n_bad = 0;
    int b_dv, b_rp, b_err, b_dvb;
    logic prev_a = 1'b0, prev_b = 1'b0;

    // Strobe counters plus exclusivity / single-cycle-width monitor.
    always @(negedge clk) begin
        if (dv_a)  n_dv_a  <= n_dv_a + 1;
        if (rp_a)  n_rp_a  <= n_rp_a + 1;
        if (err_a) n_err_a <= n_err_a + 1;
        if (dv_b)  n_dv_b  <= n_dv_b + 1;
        if ((int'(dv_a) + int'(rp_a) + int'(err_a)) > 1 ||
            (int'(dv_b) + int'(rp_b) + int'(err_b)) > 1 ||
            (prev_a && (dv_a | rp_a | err_a)) ||
            (prev_b && (dv_b | rp_b | err_b)))
            n_bad <= n_bad + 1;
        prev_a <= dv_a | rp_a | err_a;
        prev_b <= dv_b | rp_b | err_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_dv  = n_dv_a;
        b_rp  = n_rp_a;
        b_err = n_err_a;
        b_dvb = n_dv_b;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit sel_b, input logic lvl);
        if (sel_b) ir_b = lvl;
        else       ir_a = lvl;
    endtask

    task automatic drive(input bit sel_b, input logic lvl, input int ticks);
        set_line(sel_b, lvl);
        wait_cycles(ticks);
    endtask

    // Leader plus nbits data bits; with full=1 also the stop mark, ending with the
    // line released high at the stop mark's rising edge.
    task automatic send_frame(input bit sel_b, input logic [31:0] word, input int nbits,
                              input bit full);
        $display("[TB] frame %h, %0d bits, full=%0d, dut %s", word, nbits, full,
                 sel_b ? "b" : "a");
        drive(sel_b, 1'b0, T_LEAD);
        drive(sel_b, 1'b1, T_DSP);
        for (int i = 0; i < nbits; i++) begin
            drive(sel_b, 1'b0, T_MARK);
            drive(sel_b, 1'b1, word[i] ? T_ONE : T_ZERO);
        end
        if (full) begin
            drive(sel_b, 1'b0, T_MARK);
            set_line(sel_b, 1'b1);
        end
    endtask

    task automatic send_repeat();
        $display("[TB] repeat frame, dut a");
        drive(1'b0, 1'b0, T_LEAD);
        drive(1'b0, 1'b1, T_RSP);
        drive(1'b0, 1'b0, T_MARK);
        set_line(1'b0, 1'b1);
    endtask

    initial begin
        rst  = 1'b1;
        ir_a = 1'b1;
        ir_b = 1'b1;
        wait_cycles(5);
        check("reset data", data_a, 32'h0);
        check("reset data_valid", 32'(dv_a), 32'd0);
        check("reset repeat", 32'(rp_a), 32'd0);
        check("reset err", 32'(err_a), 32'd0);
        check("reset err_code", 32'(code_a), 32'd0);
        check("reset busy", 32'(busy_a), 32'd0);
        check("reset held", 32'(held_a), 32'd0);
        rst = 1'b0;
        wait_cycles(20);

        // Valid frame addr 00/FF, cmd 01/FE.
        snap();
        send_frame(1'b0, 32'hFE01FF00, 32, 1'b1);
        wait_cycles(10);
        check("frame1 dv count", 32'(n_dv_a - b_dv), 32'd1);
        check("frame1 err count", 32'(n_err_a - b_err), 32'd0);
        check("frame1 data", data_a, 32'hFE01FF00);
        check("frame1 held", 32'(held_a), 32'd1);
        check("frame1 busy", 32'(busy_a), 32'd0);

        // Repeat 40 ms after the stop, then hold expiry 120 ms after the repeat.
        wait_cycles(40 * T_MS - 10);
        snap();
        send_repeat();
        wait_cycles(10);
        check("repeat rp count", 32'(n_rp_a - b_rp), 32'd1);
        check("repeat dv count", 32'(n_dv_a - b_dv), 32'd0);
        check("repeat data", data_a, 32'hFE01FF00);
        check("repeat held", 32'(held_a), 32'd1);
        wait_cycles(119 * T_MS - 10);
        check("held at 119ms", 32'(held_a), 32'd1);
        wait_cycles(2 * T_MS);
        check("held at 121ms", 32'(held_a), 32'd0);

        // Complement failure: byte3 0xFD vs cmd 0x01.
        snap();
        send_frame(1'b0, 32'hFD01FF00, 32, 1'b1);
        wait_cycles(10);
        check("inv err count", 32'(n_err_a - b_err), 32'd1);
        check("inv dv count", 32'(n_dv_a - b_dv), 32'd0);
        check("inv err_code", 32'(code_a), 32'd2);
        check("inv data kept", data_a, 32'hFE01FF00);

        // Bit 5 space of 1000 us (50 cycles) -> timing error.
        snap();
        $display("[TB] frame with bad bit-5 space, dut a");
        drive(1'b0, 1'b0, T_LEAD);
        drive(1'b0, 1'b1, T_DSP);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, T_MARK);
            drive(1'b0, 1'b1, T_ZERO);
        end
        drive(1'b0, 1'b0, T_MARK);
        drive(1'b0, 1'b1, T_BAD);
        drive(1'b0, 1'b0, T_MARK);
        drive(1'b0, 1'b1, T_DSP);
        check("timing err count", 32'(n_err_a - b_err), 32'd1);
        check("timing err_code", 32'(code_a), 32'd1);
        check("timing busy", 32'(busy_a), 32'd0);
        snap();
        send_frame(1'b0, 32'hBA45FF00, 32, 1'b1);
        wait_cycles(10);
        check("after err dv count", 32'(n_dv_a - b_dv), 32'd1);
        check("after err err count", 32'(n_err_a - b_err), 32'd0);
        check("after err data", data_a, 32'hBA45FF00);

        // Orphan repeat straight after reset.
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(5);
        snap();
        send_repeat();
        wait_cycles(10);
        check("orphan err count", 32'(n_err_a - b_err), 32'd1);
        check("orphan rp count", 32'(n_rp_a - b_rp), 32'd0);
        check("orphan err_code", 32'(code_a), 32'd3);
        check("orphan held", 32'(held_a), 32'd0);

        // Valid frame, then reset after 10 bits of the next one.
        snap();
        send_frame(1'b0, 32'hBA45FF00, 32, 1'b1);
        wait_cycles(10);
        check("pre-reset dv count", 32'(n_dv_a - b_dv), 32'd1);
        check("pre-reset held", 32'(held_a), 32'd1);
        send_frame(1'b0, 32'hFE01FF00, 10, 1'b0);
        check("mid-frame busy", 32'(busy_a), 32'd1);
        snap();
        rst = 1'b1;
        wait_cycles(5);
        check("mid reset data", data_a, 32'h0);
        check("mid reset held", 32'(held_a), 32'd0);
        check("mid reset busy", 32'(busy_a), 32'd0);
        check("mid reset err_code", 32'(code_a), 32'd0);
        check("mid reset strobes", 32'((n_dv_a - b_dv) + (n_rp_a - b_rp) + (n_err_a - b_err)),
              32'd0);
        rst = 1'b0;
        wait_cycles(20);
        snap();
        send_frame(1'b0, 32'hFE01FF00, 32, 1'b1);
        wait_cycles(10);
        check("post reset dv count", 32'(n_dv_a - b_dv), 32'd1);
        check("post reset err count", 32'(n_err_a - b_err), 32'd0);
        check("post reset data", data_a, 32'hFE01FF00);

        // 16-bit instance, latency of exactly 3 cycles from the stop-mark rising edge.
        snap();
        send_frame(1'b1, 32'h0000FE01, 16, 1'b1);
        wait_cycles(2);
        check("b dv at +2", 32'(dv_b), 32'd0);
        wait_cycles(1);
        check("b dv at +3", 32'(dv_b), 32'd1);
        check("b data", 32'(data_b), 32'h0000FE01);
        wait_cycles(10);
        check("b dv count", 32'(n_dv_b - b_dvb), 32'd1);

        check("strobe exclusivity", 32'(n_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
